kim_counter_mc: RTL and testbench
=================================

KIM_COUNTER_MC -- requirements
Module: kim_counter_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent counter channels (1..16).
REQ-002 SHALL have parameter CNT_DATA_WIDTH, default 7, width of each channel's terminal value and count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  NUM_CH  per-channel start request, sampled each cycle.
REQ-006 SHALL have port stop  input  NUM_CH  per-channel abort request.
REQ-007 SHALL have port hold  input  NUM_CH  per-channel pause; freezes count while high.
REQ-008 SHALL have port mode  input  NUM_CH  per-channel mode captured at start: 0 = one-shot, 1 = periodic.
REQ-009 SHALL have port cnt_val  input  NUM_CH*CNT_DATA_WIDTH  per-channel terminal value; channel i occupies bits [i*CNT_DATA_WIDTH +: CNT_DATA_WIDTH].
REQ-010 SHALL have port c_cnt_o  output  NUM_CH*CNT_DATA_WIDTH  per-channel current count, same packing as cnt_val.
REQ-011 SHALL have port run_o  output  NUM_CH  high while channel state != S_IDLE.
REQ-012 SHALL have port done_o  output  NUM_CH  high while channel state == S_DONE.
REQ-013 SHALL have port err_o  output  NUM_CH  one-cycle pulse when start is rejected for cnt_val == 0.
REQ-014 SHALL have port any_done_o  output  1  OR-reduction of done_o.

Function
REQ-015 Each channel SHALL run an independent FSM: S_IDLE, S_RUN, S_DONE; no shared state between channels.
REQ-016 In S_IDLE, start=1 with stop=0 and cnt_val!=0 SHALL capture cnt_val and mode into per-channel registers and enter S_RUN next cycle with count 0.
REQ-017 In S_IDLE, start=1 with cnt_val==0 SHALL keep S_IDLE and assert err_o for exactly the next cycle.
REQ-018 In S_IDLE, start and stop together SHALL be ignored (stay S_IDLE, no capture, no err_o).
REQ-019 start in S_RUN or S_DONE SHALL be ignored; captured cnt_val/mode SHALL not change.
REQ-020 In S_RUN, hold=1 and stop=0 SHALL keep count and state unchanged.
REQ-021 In S_RUN, hold=0 and count < captured_val-1 SHALL increment count by 1 per cycle.
REQ-022 In S_RUN, hold=0 and count == captured_val-1 SHALL enter S_DONE next cycle with count 0.
REQ-023 S_DONE SHALL last exactly one cycle: next state S_RUN (count 0) if captured mode=1, else S_IDLE.
REQ-024 hold SHALL have no effect in S_DONE or S_IDLE.
REQ-025 stop=1 in S_RUN or S_DONE SHALL force S_IDLE next cycle with count 0; stop has priority over hold and terminal-count transition; done_o already high in S_DONE stays high that cycle.
REQ-026 Latency: start at edge T (one-shot, N, no hold) SHALL give run_o high for cycles T+1..T+N+1 and done_o high only in cycle T+N+1.
REQ-027 Periodic, N, no hold SHALL give done_o once every N+1 cycles until stop.
REQ-028 cnt_val==1 SHALL give one S_RUN cycle with count 0, then S_DONE.
REQ-029 Count SHALL never exceed captured_val-1; no wrap beyond CNT_DATA_WIDTH; maximum value 2^CNT_DATA_WIDTH-1 SHALL be supported.
REQ-030 run_o, done_o, any_done_o, c_cnt_o SHALL be decoded from registered state/count only (no input-to-output combinational path).

Reset
REQ-031 rst_n low SHALL immediately, asynchronously force every channel to S_IDLE, count 0, captured cnt_val 0, captured mode 0, err_o 0.
REQ-032 Reset mid-count SHALL discard the run; after release, channels stay S_IDLE until a new start.
REQ-033 All outputs SHALL be 0 during reset.

Verification
REQ-034 Ch0 one-shot, cnt_val=5, start at T -> c_cnt_o ch0 0,1,2,3,4 in T+1..T+5; done_o[0] only at T+6; run_o[0] low from T+7.
REQ-035 Ch1 periodic, cnt_val=3, stop after 3 periods -> done_o[1] at T+4, T+8, T+12; S_IDLE one cycle after stop; other channels unaffected.
REQ-036 Ch2 cnt_val=4, hold high 3 cycles when count=2 -> count holds 2 for 3 cycles; done_o[2] at T+8.
REQ-037 Ch3 start with cnt_val=0 -> err_o[3] one-cycle pulse, run_o[3]=0; start+stop in same cycle -> no effect.
REQ-038 All channels started with different values, rst_n pulsed low mid-count -> all outputs 0 at once, remain idle after release until new start.
REQ-039 Ch0 running, cnt_val changed and start re-asserted -> ignored, terminal count uses originally captured value.

Source files
------------

// File: rtl/kim_counter_mc_if.sv
// rtl/kim_counter_mc_if.sv - control/status bundle for the multi-channel counter
interface kim_counter_mc_if #(
  parameter int NUM_CH         = 4,
  parameter int CNT_DATA_WIDTH = 7
);
  logic [NUM_CH-1:0]                start;
  logic [NUM_CH-1:0]                stop;
  logic [NUM_CH-1:0]                hold;
  logic [NUM_CH-1:0]                mode;
  logic [NUM_CH*CNT_DATA_WIDTH-1:0] cnt_val;
  logic [NUM_CH*CNT_DATA_WIDTH-1:0] c_cnt_o;
  logic [NUM_CH-1:0]                run_o;
  logic [NUM_CH-1:0]                done_o;
  logic [NUM_CH-1:0]                err_o;
  logic                             any_done_o;

  modport master (
    output start, stop, hold, mode, cnt_val,
    input  c_cnt_o, run_o, done_o, err_o, any_done_o
  );

  modport slave (
    input  start, stop, hold, mode, cnt_val,
    output c_cnt_o, run_o, done_o, err_o, any_done_o
  );
endinterface

// File: rtl/kim_counter_mc.sv
// rtl/kim_counter_mc.sv - independent per-channel one-shot/periodic counters
module kim_counter_mc #(
  parameter int NUM_CH         = 4,
  parameter int CNT_DATA_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  kim_counter_mc_if.slave       bus
);

  localparam int W = CNT_DATA_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state     [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [W-1:0]      r_cnt       [NUM_CH];
  logic [W-1:0]      w_cnt_nxt   [NUM_CH];
  logic [W-1:0]      r_val       [NUM_CH];
  logic [W-1:0]      w_val_nxt   [NUM_CH];
  logic [W-1:0]      w_cnt_in    [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] w_mode_nxt;
  logic [NUM_CH-1:0] r_err;
  logic [NUM_CH-1:0] w_err_nxt;

  logic [NUM_CH*W-1:0] w_cnt_packed;
  logic [NUM_CH-1:0]   w_run;
  logic [NUM_CH-1:0]   w_done;

  // unpack the per-channel terminal values
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_in[i] = bus.cnt_val[i*W +: W];
    end
  end

  // per-channel next state: stop beats hold and terminal count; a zero terminal flags an error
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_val_nxt[i]   = r_val[i];
      w_mode_nxt[i]  = r_mode[i];
      w_err_nxt[i]   = 1'b0;
      case (r_state[i])
        S_IDLE: begin
          if (bus.start[i] && !bus.stop[i]) begin
            if (w_cnt_in[i] == '0) begin
              w_err_nxt[i] = 1'b1;
            end else begin
              w_state_nxt[i] = S_RUN;
              w_cnt_nxt[i]   = '0;
              w_val_nxt[i]   = w_cnt_in[i];
              w_mode_nxt[i]  = bus.mode[i];
            end
          end
        end
        S_RUN: begin
          if (bus.stop[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end else if (!bus.hold[i]) begin
            if (r_cnt[i] == (r_val[i] - ONE)) begin
              w_state_nxt[i] = S_DONE;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + ONE;
            end
          end
        end
        S_DONE: begin
          w_cnt_nxt[i] = '0;
          if (bus.stop[i]) begin
            w_state_nxt[i] = S_IDLE;
          end else if (r_mode[i]) begin
            w_state_nxt[i] = S_RUN;
          end else begin
            w_state_nxt[i] = S_IDLE;
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // state, count, captured terminal/mode and error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_val[i]   <= '0;
      end
      r_mode <= '0;
      r_err  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_val[i]   <= w_val_nxt[i];
      end
      r_mode <= w_mode_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // status outputs decoded from registered state only
  always_comb begin
    w_cnt_packed = '0;
    w_run        = '0;
    w_done       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_packed[i*W +: W] = r_cnt[i];
      w_run[i]               = (r_state[i] != S_IDLE);
      w_done[i]              = (r_state[i] == S_DONE);
    end
  end

  assign bus.c_cnt_o    = w_cnt_packed;
  assign bus.run_o      = w_run;
  assign bus.done_o     = w_done;
  assign bus.err_o      = r_err;
  assign bus.any_done_o = |w_done;

endmodule

// File: tb/tb_kim_counter_mc.sv
// tb/tb_kim_counter_mc.sv - scoreboard bench for kim_counter_mc
module tb_kim_counter_mc;
  localparam int NCH = 4;
  localparam int W   = 7;

  localparam int K_CNT  = 0;
  localparam int K_RUN  = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;
  localparam int K_ANY  = 4;

  typedef struct {
    int    at;
    int    kind;
    int    ch;
    int    val;
    string tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  kim_counter_mc_if #(.NUM_CH(NCH), .CNT_DATA_WIDTH(W)) bus ();

  kim_counter_mc #(.NUM_CH(NCH), .CNT_DATA_WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int observe(input int kind, input int ch);
    case (kind)
      K_CNT:   return int'(bus.c_cnt_o[ch*W +: W]);
      K_RUN:   return int'(bus.run_o[ch]);
      K_DONE:  return int'(bus.done_o[ch]);
      K_ERR:   return int'(bus.err_o[ch]);
      default: return int'(bus.any_done_o);
    endcase
  endfunction

  task automatic push(input int at, input int kind, input int ch, input int val, input string tag);
    exp_t e;
    int   idx;
    e.at = at; e.kind = kind; e.ch = ch; e.val = val; e.tag = tag;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].at > at) idx--;
    sb.insert(idx, e);
  endtask

  // one-shot of length n started at sample point c: count 0..n-1, done at n+1, idle at n+2
  task automatic sched_oneshot(input int ch, input int n, input int c, input string pfx);
    for (int k = 1; k <= n + 2; k++) begin
      push(c + k, K_CNT,  ch, (k <= n) ? k - 1 : 0, $sformatf("%s_cnt%0d_k%0d", pfx, ch, k));
      push(c + k, K_RUN,  ch, (k <= n + 1) ? 1 : 0,  $sformatf("%s_run%0d_k%0d", pfx, ch, k));
      push(c + k, K_DONE, ch, (k == n + 1) ? 1 : 0,  $sformatf("%s_done%0d_k%0d", pfx, ch, k));
      if (k == 1) push(c + k, K_ERR, ch, 0, $sformatf("%s_err%0d", pfx, ch));
    end
  endtask

  // periodic of length n: done once every n+1 cycles
  task automatic sched_periodic(input int ch, input int n, input int c, input int kmax, input string pfx);
    int r;
    for (int k = 1; k <= kmax; k++) begin
      r = k % (n + 1);
      push(c + k, K_DONE, ch, (r == 0) ? 1 : 0,     $sformatf("%s_done%0d_k%0d", pfx, ch, k));
      push(c + k, K_CNT,  ch, (r == 0) ? 0 : r - 1, $sformatf("%s_cnt%0d_k%0d", pfx, ch, k));
      push(c + k, K_RUN,  ch, 1,                    $sformatf("%s_run%0d_k%0d", pfx, ch, k));
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at != cyc) check_val({mon_e.tag, "_late"}, cyc, mon_e.at);
      else                 check_val(mon_e.tag, observe(mon_e.kind, mon_e.ch), mon_e.val);
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cnt"},  int'(bus.c_cnt_o), 0);
    check_val({tag, "_run"},  int'(bus.run_o), 0);
    check_val({tag, "_done"}, int'(bus.done_o), 0);
    check_val({tag, "_err"},  int'(bus.err_o), 0);
    check_val({tag, "_any"},  int'(bus.any_done_o), 0);
  endtask

  int c;
  int hold_cnt [7] = '{0, 1, 2, 2, 2, 2, 3};

  initial begin
    rst_n = 1'b0;
    bus.start = '0; bus.stop = '0; bus.hold = '0; bus.mode = '0; bus.cnt_val = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // one-shot ch0 N=5, with any_done
    c = cyc;
    bus.cnt_val[0*W +: W] = 7'd5; bus.mode[0] = 1'b0; bus.start[0] = 1'b1;
    sched_oneshot(0, 5, c, "os5");
    push(c + 5, K_ANY, 0, 0, "os5_any_k5");
    push(c + 6, K_ANY, 0, 1, "os5_any_k6");
    push(c + 7, K_ANY, 0, 0, "os5_any_k7");
    @(negedge clk); bus.start = '0;
    repeat (8) @(negedge clk);

    // terminal value 1
    c = cyc;
    bus.cnt_val[0*W +: W] = 7'd1; bus.start[0] = 1'b1;
    sched_oneshot(0, 1, c, "os1");
    @(negedge clk); bus.start = '0;
    repeat (4) @(negedge clk);

    // maximum terminal value
    c = cyc;
    bus.cnt_val[0*W +: W] = 7'd127; bus.start[0] = 1'b1;
    sched_oneshot(0, 127, c, "os127");
    @(negedge clk); bus.start = '0;
    repeat (131) @(negedge clk);

    // ch1 periodic N=3 stopped in its third DONE, ch0 one-shot alongside
    c = cyc;
    bus.cnt_val[1*W +: W] = 7'd3; bus.mode[1] = 1'b1;
    bus.cnt_val[0*W +: W] = 7'd5; bus.mode[0] = 1'b0;
    bus.start = 4'b0011;
    sched_periodic(1, 3, c, 12, "per3");
    sched_oneshot(0, 5, c, "per_os0");
    push(c + 13, K_RUN,  1, 0, "per3_stop_run");
    push(c + 13, K_DONE, 1, 0, "per3_stop_done");
    push(c + 13, K_CNT,  1, 0, "per3_stop_cnt");
    push(c + 15, K_RUN,  1, 0, "per3_stay_idle");
    @(negedge clk); bus.start = '0; bus.mode[1] = 1'b0;
    repeat (11) @(negedge clk);
    bus.stop[1] = 1'b1;
    @(negedge clk); bus.stop = '0;
    repeat (4) @(negedge clk);

    // ch2 hold for three cycles at count 2
    c = cyc;
    bus.cnt_val[2*W +: W] = 7'd4; bus.start[2] = 1'b1;
    for (int k = 1; k <= 7; k++) push(c + k, K_CNT, 2, hold_cnt[k-1], $sformatf("hold_cnt_k%0d", k));
    push(c + 7, K_DONE, 2, 0, "hold_done_k7");
    push(c + 8, K_DONE, 2, 1, "hold_done_k8");
    push(c + 9, K_RUN,  2, 0, "hold_run_k9");
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = '0;
      bus.hold[2] = (k >= 3 && k <= 5);
    end
    bus.hold = '0;

    // stop with hold in RUN: stop wins
    c = cyc;
    bus.cnt_val[2*W +: W] = 7'd10; bus.start[2] = 1'b1;
    for (int k = 1; k <= 3; k++) push(c + k, K_CNT, 2, k - 1, $sformatf("stp_cnt_k%0d", k));
    push(c + 4, K_RUN, 2, 0, "stp_run_k4");
    push(c + 4, K_CNT, 2, 0, "stp_cnt_k4");
    push(c + 6, K_RUN, 2, 0, "stp_run_k6");
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.start = '0;
      bus.stop[2] = (k == 3);
      bus.hold[2] = (k == 3);
    end
    bus.stop = '0; bus.hold = '0;

    // ch3 zero terminal value -> error pulse
    c = cyc;
    bus.cnt_val[3*W +: W] = 7'd0; bus.start[3] = 1'b1;
    push(c + 1, K_ERR, 3, 1, "zero_err_k1");
    push(c + 2, K_ERR, 3, 0, "zero_err_k2");
    push(c + 1, K_RUN, 3, 0, "zero_run_k1");
    push(c + 2, K_RUN, 3, 0, "zero_run_k2");
    @(negedge clk); bus.start = '0;
    repeat (3) @(negedge clk);

    // ch3 start together with stop -> ignored
    c = cyc;
    bus.cnt_val[3*W +: W] = 7'd6; bus.start[3] = 1'b1; bus.stop[3] = 1'b1;
    push(c + 1, K_RUN, 3, 0, "ss_run_k1");
    push(c + 1, K_ERR, 3, 0, "ss_err_k1");
    push(c + 2, K_RUN, 3, 0, "ss_run_k2");
    push(c + 2, K_CNT, 3, 0, "ss_cnt_k2");
    @(negedge clk); bus.start = '0; bus.stop = '0;
    repeat (3) @(negedge clk);

    // restart while running is ignored, original terminal/mode kept
    c = cyc;
    bus.cnt_val[0*W +: W] = 7'd6; bus.mode[0] = 1'b0; bus.start[0] = 1'b1;
    sched_oneshot(0, 6, c, "rst39");
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.start[0] = (k == 2);
      if (k == 2) begin
        bus.cnt_val[0*W +: W] = 7'd2;
        bus.mode[0] = 1'b1;
      end
    end
    bus.start = '0; bus.mode = '0;

    // reset mid-count on all channels
    c = cyc;
    for (int i = 0; i < NCH; i++) begin
      bus.cnt_val[i*W +: W] = 7'(10 * (i + 1));
      push(c + 4, K_CNT, i, 3, $sformatf("mr_cnt%0d_k4", i));
      push(c + 4, K_RUN, i, 1, $sformatf("mr_run%0d_k4", i));
    end
    bus.start = 4'hF;
    @(negedge clk); bus.start = '0;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    check_all_zero("in_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_all_zero($sformatf("post_rst_%0d", k));
    end

    // fresh start after reset
    c = cyc;
    bus.cnt_val[1*W +: W] = 7'd2; bus.start[1] = 1'b1;
    sched_oneshot(1, 2, c, "after_rst");
    @(negedge clk); bus.start = '0;
    repeat (6) @(negedge clk);

    check_val("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
